// File: rtl/timer_pkg.sv
// Shared types and constants for the keypad timer run-time controller.
// The snooze helper below is only referenced when TIMER_SNOOZE_EN is defined.
package timer_pkg;

    localparam int unsigned HOUR_W = 5;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned SEC_W  = 6;

    localparam logic [HOUR_W-1:0] HOUR_MAX   = HOUR_W'(23);
    localparam logic [MIN_W-1:0]  MIN_MAX    = MIN_W'(59);
    localparam logic [SEC_W-1:0]  SEC_MAX    = SEC_W'(59);
    localparam logic [MIN_W-1:0]  SNOOZE_MIN = MIN_W'(5);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        FIRING = 2'd2
    } run_state_t;

    // Hour/minute pair used for the alarm target.
    typedef struct packed {
        logic [HOUR_W-1:0] h;
        logic [MIN_W-1:0]  m;
    } hm_t;

    // Advance a time of day by delta minutes (delta < 60), wrapping 23:xx to 00:xx.
    function automatic hm_t add_minutes(input hm_t t, input logic [MIN_W-1:0] delta);
        hm_t        r;
        logic [6:0] m;
        r = t;
        m = 7'(t.m) + 7'(delta);
        if (m > 7'(MIN_MAX)) begin
            r.m = MIN_W'(m - 7'd60);
            r.h = (t.h >= HOUR_MAX) ? '0 : t.h + HOUR_W'(1);
        end else begin
            r.m = MIN_W'(m);
        end
        return r;
    endfunction

endpackage

// File: rtl/sec_prescaler.sv
// Divides mclk down to a one-cycle tick once per second.
// The tick is registered: it is high exactly while the count sits at TICKS_PER_SEC-1.
module sec_prescaler #(
    parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
    input  logic mclk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned      CW   = $clog2(TICKS_PER_SEC);
    localparam logic [CW-1:0]    LAST = CW'(TICKS_PER_SEC - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    // Wrap at the last count; a clear restarts the second.
    always_comb begin
        cnt_nxt = cnt + CW'(1);
        if (clr || (cnt == LAST)) begin
            cnt_nxt = '0;
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            tick <= (cnt_nxt == LAST);
        end
    end

endmodule

// File: rtl/timer_run_ctrl.sv
// Run-time controller: wall clock, alarm target latch and IDLE/ARMED/FIRING sequencing.
// Define TIMER_SNOOZE_EN to add the snooze input (re-arm current time + 5 minutes).
module timer_run_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 50_000_000,
    parameter int unsigned ALARM_SEC     = 60
) (
    input  logic              mclk,
    input  logic              rst_n,
    input  logic              set,
    input  logic [HOUR_W-1:0] nowH,
    input  logic [MIN_W-1:0]  nowM,
    input  logic [HOUR_W-1:0] timerH,
    input  logic [MIN_W-1:0]  timerM,
    input  logic              run_enable,
    input  logic              stop,
`ifdef TIMER_SNOOZE_EN
    input  logic              snooze,
`endif
    output logic [HOUR_W-1:0] curH,
    output logic [MIN_W-1:0]  curM,
    output logic [SEC_W-1:0]  curS,
    output logic              sec_tick,
    output logic              alarm,
    output logic [1:0]        state
);

    localparam int unsigned       DUR_W    = $clog2(ALARM_SEC + 1);
    localparam logic [DUR_W-1:0]  DUR_LAST = DUR_W'(ALARM_SEC - 1);

    logic              tick;
    logic              run_q;
    logic              run_rise;
    logic              at_target;
    run_state_t        st;
    run_state_t        st_nxt;
    hm_t               tgt;
    hm_t               tgt_nxt;
    logic [DUR_W-1:0]  dur;
    logic [DUR_W-1:0]  dur_nxt;
    logic [HOUR_W-1:0] h_nxt;
    logic [MIN_W-1:0]  m_nxt;
    logic [SEC_W-1:0]  s_nxt;

    sec_prescaler #(
        .TICKS_PER_SEC (TICKS_PER_SEC)
    ) u_presc (
        .mclk  (mclk),
        .rst_n (rst_n),
        .clr   (set),
        .tick  (tick)
    );

    assign sec_tick  = tick;
    assign state     = st;
    assign run_rise  = run_enable & ~run_q;
    assign at_target = (curH == tgt.h) && (curM == tgt.m) && (curS == '0);

    // Wall clock: a load from the keypad wins over the once-per-second advance.
    always_comb begin
        h_nxt = curH;
        m_nxt = curM;
        s_nxt = curS;
        if (set) begin
            h_nxt = nowH;
            m_nxt = nowM;
            s_nxt = '0;
        end else if (tick) begin
            if (curS >= SEC_MAX) begin
                s_nxt = '0;
                if (curM >= MIN_MAX) begin
                    m_nxt = '0;
                    h_nxt = (curH >= HOUR_MAX) ? '0 : curH + HOUR_W'(1);
                end else begin
                    m_nxt = curM + MIN_W'(1);
                end
            end else begin
                s_nxt = curS + SEC_W'(1);
            end
        end
    end

    // Alarm sequencing; an arm edge overrides whatever the state logic chose.
    always_comb begin
        st_nxt  = st;
        tgt_nxt = tgt;
        dur_nxt = dur;
        case (st)
            IDLE: begin
                st_nxt = IDLE;
            end
            ARMED: begin
                if (at_target) begin
                    st_nxt  = FIRING;
                    dur_nxt = '0;
                end
            end
            FIRING: begin
                if (set || stop) begin
                    st_nxt = IDLE;
                end
`ifdef TIMER_SNOOZE_EN
                else if (snooze) begin
                    st_nxt  = ARMED;
                    tgt_nxt = add_minutes('{h: curH, m: curM}, SNOOZE_MIN);
                end
`endif
                else if (tick && (dur == DUR_LAST)) begin
                    st_nxt = IDLE;
                end else if (tick) begin
                    dur_nxt = dur + DUR_W'(1);
                end
            end
            default: begin
                st_nxt = IDLE;
            end
        endcase
        if (run_rise) begin
            st_nxt  = ARMED;
            tgt_nxt = '{h: timerH, m: timerM};
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            st <= IDLE;
        end else begin
            st <= st_nxt;
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            curH  <= '0;
            curM  <= '0;
            curS  <= '0;
            tgt   <= '0;
            dur   <= '0;
            run_q <= 1'b0;
            alarm <= 1'b0;
        end else begin
            curH  <= h_nxt;
            curM  <= m_nxt;
            curS  <= s_nxt;
            tgt   <= tgt_nxt;
            dur   <= dur_nxt;
            run_q <= run_enable;
            alarm <= (st_nxt == FIRING);
        end
    end

endmodule

// File: tb/tb_timer_run_ctrl.sv
// Directed bench for timer_run_ctrl with TICKS_PER_SEC=4 and ALARM_SEC=3.
// Build with TIMER_SNOOZE_EN defined to include the snooze scenario.
module tb_timer_run_ctrl;

    logic       mclk;
    logic       rst_n;
    logic       set;
    logic [4:0] nowH;
    logic [5:0] nowM;
    logic [4:0] timerH;
    logic [5:0] timerM;
    logic       run_enable;
    logic       stop;
`ifdef TIMER_SNOOZE_EN
    logic       snooze;
`endif
    logic [4:0] curH;
    logic [5:0] curM;
    logic [5:0] curS;
    logic       sec_tick;
    logic       alarm;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;

    timer_run_ctrl #(
        .TICKS_PER_SEC (4),
        .ALARM_SEC     (3)
    ) dut (
        .mclk       (mclk),
        .rst_n      (rst_n),
        .set        (set),
        .nowH       (nowH),
        .nowM       (nowM),
        .timerH     (timerH),
        .timerM     (timerM),
        .run_enable (run_enable),
        .stop       (stop),
`ifdef TIMER_SNOOZE_EN
        .snooze     (snooze),
`endif
        .curH       (curH),
        .curM       (curM),
        .curS       (curS),
        .sec_tick   (sec_tick),
        .alarm      (alarm),
        .state      (state)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge mclk);
        #1;
    endtask

    initial begin
        int n;
        int terr;
        int tcnt;
        int refire;

        rst_n = 1'b0; set = 1'b0; nowH = '0; nowM = '0; timerH = '0; timerM = '0;
        run_enable = 1'b0; stop = 1'b0;
`ifdef TIMER_SNOOZE_EN
        snooze = 1'b0;
`endif
        cyc(); cyc();
        chk("rst_curH", curH, 0);
        chk("rst_curM", curM, 0);
        chk("rst_curS", curS, 0);
        chk("rst_tick", sec_tick, 0);
        chk("rst_alarm", alarm, 0);
        chk("rst_state", state, 0);
        rst_n = 1'b1;

        // Wrap: 23:59:00 plus 60 seconds
        set = 1'b1; nowH = 5'd23; nowM = 6'd59;
        cyc();
        set = 1'b0;
        chk("set_curH", curH, 23);
        chk("set_curM", curM, 59);
        chk("set_curS", curS, 0);
        terr = 0; tcnt = 0;
        for (int i = 1; i <= 240; i++) begin
            cyc();
            if (sec_tick) tcnt++;
            if (sec_tick !== ((i % 4) == 3)) terr++;
        end
        chk("wrap_curH", curH, 0);
        chk("wrap_curM", curM, 0);
        chk("wrap_curS", curS, 0);
        chk("tick_count", tcnt, 60);
        chk("tick_period_err", terr, 0);

        // Set coincident with sec_tick
        cyc(); cyc(); cyc();
        chk("pre_coll_tick", sec_tick, 1);
        set = 1'b1; nowH = 5'd5; nowM = 6'd30;
        cyc();
        set = 1'b0;
        chk("coll_curH", curH, 5);
        chk("coll_curM", curM, 30);
        chk("coll_curS", curS, 0);
        cyc(); cyc(); cyc();
        chk("coll_hold_S", curS, 0);
        cyc();
        chk("coll_next_S", curS, 1);

        // Fire and timeout
        set = 1'b1; nowH = 5'd10; nowM = 6'd0;
        cyc();
        set = 1'b0; timerH = 5'd10; timerM = 6'd1; run_enable = 1'b1;
        cyc();
        chk("arm_state", state, 1);
        n = 0;
        while (curM !== 6'd1 && n < 300) begin
            cyc();
            n++;
        end
        chk("reach_1001", curM, 1);
        chk("match_curS", curS, 0);
        chk("match_alarm", alarm, 0);
        chk("match_state", state, 1);
        cyc();
        chk("fire_alarm", alarm, 1);
        chk("fire_state", state, 2);
        n = 1;
        while (alarm === 1'b1 && n < 50) begin
            cyc();
            if (alarm === 1'b1) n++;
        end
        chk("alarm_high_cycles", n, 11);
        chk("timeout_state", state, 0);
        refire = 0;
        for (int i = 0; i < 228; i++) begin
            cyc();
            if (alarm !== 1'b0) refire++;
        end
        chk("no_refire", refire, 0);
        chk("after_1001_curM", curM, 2);

        // Arm while already matching, then stop
        run_enable = 1'b0; set = 1'b1; nowH = 5'd7; nowM = 6'd0;
        cyc();
        set = 1'b0; timerH = 5'd7; timerM = 6'd0; run_enable = 1'b1;
        cyc();
        chk("arm2_state", state, 1);
        cyc();
        chk("arm2_fire_alarm", alarm, 1);
        chk("arm2_fire_state", state, 2);
        cyc();
        chk("arm2_still_firing", alarm, 1);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("stop_alarm", alarm, 0);
        chk("stop_state", state, 0);

        // Set during FIRING aborts
        run_enable = 1'b0; set = 1'b1; nowH = 5'd8; nowM = 6'd0;
        cyc();
        set = 1'b0; timerH = 5'd8; timerM = 6'd0; run_enable = 1'b1;
        cyc(); cyc();
        chk("sf_fire_alarm", alarm, 1);
        set = 1'b1; nowH = 5'd9; nowM = 6'd0; run_enable = 1'b0;
        cyc();
        set = 1'b0;
        chk("sf_state", state, 0);
        chk("sf_alarm", alarm, 0);
        chk("sf_curH", curH, 9);

        // Set in ARMED keeps the arm; loading the target time fires next cycle
        timerH = 5'd12; timerM = 6'd0; run_enable = 1'b1;
        cyc();
        chk("sa_armed", state, 1);
        set = 1'b1; nowH = 5'd11; nowM = 6'd59;
        cyc();
        chk("sa_still_armed", state, 1);
        chk("sa_curH", curH, 11);
        nowH = 5'd12; nowM = 6'd0;
        cyc();
        set = 1'b0;
        chk("sa_armed_at_match", state, 1);
        cyc();
        chk("sa_fire_alarm", alarm, 1);

        // Asynchronous reset mid-FIRING
        #2;
        rst_n = 1'b0; run_enable = 1'b0;
        #1;
        chk("arst_alarm", alarm, 0);
        chk("arst_state", state, 0);
        chk("arst_curH", curH, 0);
        chk("arst_curM", curM, 0);
        chk("arst_curS", curS, 0);
        chk("arst_tick", sec_tick, 0);
        @(posedge mclk);
        #1;
        rst_n = 1'b1;
        timerH = 5'd0; timerM = 6'd0; run_enable = 1'b1;
        cyc();
        chk("rearm_state", state, 1);
        cyc();
        chk("rearm_alarm", alarm, 1);
        stop = 1'b1;
        cyc();
        stop = 1'b0; run_enable = 1'b0;
        chk("rearm_stop", alarm, 0);

`ifdef TIMER_SNOOZE_EN
        // Snooze at 23:58 re-arms for 00:03
        set = 1'b1; nowH = 5'd23; nowM = 6'd58;
        cyc();
        set = 1'b0; timerH = 5'd23; timerM = 6'd58; run_enable = 1'b1;
        cyc(); cyc();
        chk("sn_fire", alarm, 1);
        snooze = 1'b1;
        cyc();
        snooze = 1'b0;
        chk("sn_state", state, 1);
        chk("sn_alarm", alarm, 0);
        n = 0;
        while (!(curH === 5'd0 && curM === 6'd3) && n < 1300) begin
            cyc();
            n++;
            if (alarm !== 1'b0) refire++;
        end
        chk("sn_early_fire", refire, 0);
        chk("sn_reach_H", curH, 0);
        chk("sn_reach_M", curM, 3);
        chk("sn_reach_state", state, 1);
        cyc();
        chk("sn_refire_alarm", alarm, 1);
        chk("sn_refire_state", state, 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/timer_run_ctrl.md
# timer_run_ctrl

Run-time controller for the keypad timer. Keeps the wall clock running from the master clock, latches the timer target when setup completes, and sequences the alarm: arm, fire, time out or stop. It sits downstream of the keypad setup FSM, which supplies `set`, the time fields and `run_enable`. It drives the display time and the alarm output.

## Interface
- `TICKS_PER_SEC`, default 50_000_000: `mclk` cycles per second; ≥2.
- `ALARM_SEC`, default 60: alarm duration in seconds; ≥1.
- `mclk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `set`  in  1  one-cycle pulse: load `nowH`/`nowM` into the clock.
- `nowH`  in  5  hour to load, 0–23.
- `nowM`  in  6  minute to load, 0–59.
- `timerH`  in  5  alarm hour, 0–23.
- `timerM`  in  6  alarm minute, 0–59.
- `run_enable`  in  1  level; its rising edge arms the alarm.
- `stop`  in  1  one-cycle pulse: silence the alarm.
- `snooze`  in  1  one-cycle pulse; present only with `TIMER_SNOOZE_EN`.
- `curH`  out  5  current hour.
- `curM`  out  6  current minute.
- `curS`  out  6  current second.
- `sec_tick`  out  1  one-cycle pulse, once per second.
- `alarm`  out  1  high while the FSM is in FIRING.
- `state`  out  2  FSM state encoding: IDLE=0, ARMED=1, FIRING=2.

## Operation
- Reset: all outputs 0, prescaler 0, target 00:00, state IDLE, `run_enable` edge register 0.
- Prescaler: counts 0..TICKS_PER_SEC-1. `sec_tick` is high in the cycle the count is TICKS_PER_SEC-1; the count then wraps to 0.
- Clock update on `sec_tick`: `curS` counts 0..59 and carries into `curM`, which counts 0..59 and carries into `curH`, which counts 0..23. 23:59:59 wraps to 00:00:00.
- `set`: `curH`←`nowH`, `curM`←`nowM`, `curS`←0, prescaler←0. `set` overrides a tick in the same cycle.
- `set` during FIRING aborts the alarm and goes to IDLE. `set` in ARMED leaves the FSM armed.
- Out-of-range `nowH`/`timerH`/`nowM`/`timerM` values are loaded as given; correct wrap behaviour is not required for them.
- Arm: a rising edge of `run_enable` latches `timerH`/`timerM` into the target and forces ARMED. This applies from any state, except that a `set` in the same cycle takes priority for the time fields only.
- FSM:
  - IDLE→ARMED on a `run_enable` rising edge.
  - ARMED→FIRING when registered `curH`==target hour, `curM`==target minute and `curS`==0.
  - FIRING→IDLE on `stop`, or on the `sec_tick` at which the duration counter equals ALARM_SEC-1.
  - FIRING→IDLE on `set`.
- Duration counter: cleared on entry to FIRING, incremented on each `sec_tick` while in FIRING.
- Each arm fires at most once; the FSM returns to IDLE, never to ARMED, unless snooze is used.
- Priority in FIRING, highest first: `set`, `stop`, `snooze`, timeout.

## Timing
- `cur*` update on the clock edge that ends the `sec_tick` cycle.
- `alarm` rises one cycle after the matching time appears on `cur*`.
- `alarm` falls on the edge after `stop`. The `alarm` high-time is ALARM_SEC seconds ±1 tick.
- `set` is reflected on `cur*` one cycle later.
- An arm is visible on `state` one cycle after the `run_enable` edge.
- If the FSM arms while `cur*` already match the target at second 0, `alarm` fires on the following cycle.
- `rst_n` asserted mid-FIRING drops `alarm` immediately (asynchronous reset).

## Configuration
- `TIMER_SNOOZE_EN` defined:
  - `snooze` port exists.
  - `snooze` in FIRING sets the target to current time +5 minutes, wrapping minute to hour and 23 to 0, and goes to ARMED.
  - `snooze` outside FIRING is ignored.
- `TIMER_SNOOZE_EN` undefined: `snooze` port and its logic are absent. The other behaviour is identical.

## Structure
- Package `timer_pkg` holds:
  - `run_state_t` enum: IDLE, ARMED, FIRING.
  - Constants `HOUR_MAX`=23, `MIN_MAX`=59, `SEC_MAX`=59, `SNOOZE_MIN`=5.
- Sub-module `sec_prescaler`, parameterised by TICKS_PER_SEC, with inputs `mclk`, `rst_n`, `clr` and output `tick`.

## Test plan
All scenarios use TICKS_PER_SEC=4 and ALARM_SEC=3.
- Wrap: `set` 23:59, run 60 ticks → `cur*` reads 00:00:00, `sec_tick` period is exactly 4 cycles.
- Fire/timeout: `set` 10:00, target 10:01, arm → `alarm` rises 1 cycle after 10:01:00 appears, falls after 3 ticks, `state`=IDLE, no refire during 10:01.
- Stop: `stop` 2 cycles into FIRING → `alarm`=0 on the next edge, `state`=IDLE.
- Collisions: `set` coincident with `sec_tick` → loaded value held with `curS`=0 and no increment. `set` during FIRING → IDLE.
- Reset: `rst_n` low mid-FIRING → all outputs 0 asynchronously. Re-arm after release works.
- Snooze (`TIMER_SNOOZE_EN`): FIRING at 23:58 plus `snooze` → ARMED with target 00:03, fires at 00:03:00.
